// File: rtl/fact_seq.sv
// Sequential factorial engine.
// A start pulse captures n; the engine iterates acc *= cnt for cnt = 2..n and
// each multiply runs on a shift-add datapath that consumes one multiplier bit
// per cycle. The result is presented with a one-cycle done pulse. Overflow
// flags that the true n! did not fit in OUT_W bits.
module fact_seq #(
  parameter int SIZE  = 8,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SIZE-1:0]  n,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] result,
  output logic             overflow
);

  // Counter is one bit wider than n so that n = 2^SIZE-1 still terminates.
  localparam int CW = SIZE + 1;
  // Product register holds acc * cnt exactly: OUT_W bits times CW bits.
  localparam int PW = OUT_W + SIZE + 1;
  localparam int BW = (SIZE + 1 > 1) ? $clog2(SIZE + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    CMP,
    MUL,
    DONE
  } state_t;

  state_t           state;
  logic [SIZE-1:0]  n_r;
  logic [OUT_W-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             ovf_r;
  logic [OUT_W-1:0] mcand;
  logic [CW-1:0]    mplier;
  logic [PW-1:0]    prod;
  logic [BW-1:0]    bitc;

  logic [PW-1:0]    addend;
  logic [PW-1:0]    prod_sum;
  logic             last_bit;
  logic             prod_hi_nz;

  // Shift-add step: partial product for the current multiplier bit.
  always_comb begin
    addend     = '0;
    if (mplier[bitc]) begin
      addend = PW'(mcand) << bitc;
    end
    prod_sum   = prod + addend;
    last_bit   = (bitc == BW'(SIZE));
    prod_hi_nz = |prod_sum[PW-1:OUT_W];
  end

  // Control FSM with datapath updates and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      n_r      <= '0;
      acc      <= '0;
      cnt      <= '0;
      ovf_r    <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      prod     <= '0;
      bitc     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            n_r   <= n;
            state <= INIT;
            busy  <= 1'b1;
          end
        end

        INIT: begin
          acc   <= OUT_W'(1);
          cnt   <= CW'(2);
          ovf_r <= 1'b0;
          state <= CMP;
        end

        CMP: begin
          if (cnt > {1'b0, n_r}) begin
            result   <= acc;
            overflow <= ovf_r;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            mcand  <= acc;
            mplier <= cnt;
            prod   <= '0;
            bitc   <= '0;
            state  <= MUL;
          end
        end

        MUL: begin
          prod <= prod_sum;
          if (last_bit) begin
            acc   <= prod_sum[OUT_W-1:0];
            ovf_r <= ovf_r | prod_hi_nz;
            cnt   <= cnt + CW'(1);
            state <= CMP;
          end else begin
            bitc <= bitc + BW'(1);
          end
        end

        DONE: begin
          done <= 1'b0;
          if (start) begin
            n_r   <= n;
            state <= INIT;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fact_seq.sv
// Bench for fact_seq: a job-level model predicts busy/done/result/overflow for
// every cycle from accepted requests and their latency; a few literal values
// pin the model to known factorials and timings.
module tb_fact_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  n = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;

  fact_seq #(.SIZE(8), .OUT_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .n        (n),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Job-level model state
  bit          have_job = 1'b0;
  int          job_start = 0;
  int          job_due = 0;
  int          prev_due = -1;
  logic [31:0] job_res = '0;
  logic [31:0] prev_res = '0;
  bit          job_ovf = 1'b0;
  bit          prev_ovf = 1'b0;

  int busy_cnt = 0;
  int last_done = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // n! mod 2^32 and whether the true n! reaches 2^32.
  function automatic void fact_model(input int nv, output logic [31:0] r, output bit o);
    longint unsigned big;
    r   = 32'd1;
    o   = 1'b0;
    big = 1;
    for (int i = 2; i <= nv; i++) begin
      r   = r * 32'(i);
      big = big * longint'(i);
      if (big >= 64'h1_0000_0000) begin
        o   = 1'b1;
        big = 64'h1_0000_0000;
      end
    end
  endfunction

  function automatic int lat(input int nv);
    return (nv <= 1) ? 3 : 3 + (nv - 1) * 10;
  endfunction

  // Drive one cycle of inputs; model decides whether the request is taken.
  task automatic drive(input bit st, input int nv);
    start = st;
    n     = nv[7:0];
    if (st && rst_n && (!have_job || job_due <= cyc)) begin
      if (have_job) begin
        prev_res = job_res;
        prev_ovf = job_ovf;
        prev_due = job_due;
      end
      have_job  = 1'b1;
      job_start = cyc;
      job_due   = cyc + lat(nv);
      fact_model(nv, job_res, job_ovf);
      $display("accept n=%0d cycle=%0d expect result=%0d overflow=%0b due=%0d",
               nv, cyc, job_res, job_ovf, job_due);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) drive(1'b0, 0);
  endtask

  task automatic run_job(input int nv, output int s);
    s = cyc;
    busy_cnt = 0;
    drive(1'b1, nv);
    idle(lat(nv));
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic        e_busy;
    logic        e_done;
    logic [31:0] e_res;
    logic        e_ovf;
    if (!rst_n) begin
      e_busy = 1'b0; e_done = 1'b0; e_res = '0; e_ovf = 1'b0;
    end else begin
      e_busy = have_job && (cyc > job_start) && (cyc < job_due);
      e_done = (have_job && cyc == job_due) || (cyc == prev_due);
      e_res  = (have_job && cyc >= job_due) ? job_res : prev_res;
      e_ovf  = (have_job && cyc >= job_due) ? job_ovf : prev_ovf;
    end
    chk("busy", 64'(busy), 64'(e_busy));
    chk("done", 64'(done), 64'(e_done));
    chk("result", 64'(result), 64'(e_res));
    chk("overflow", 64'(overflow), 64'(e_ovf));
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) begin
      last_done = cyc;
      $display("done cycle=%0d result=%0d overflow=%0b", cyc, result, overflow);
    end
  end

  initial begin
    int s;
    logic [31:0] mr;
    bit mo;

    // Pin the model to hand-computed values.
    fact_model(12, mr, mo);
    chk("model_12", 64'(mr), 64'd479001600);
    fact_model(13, mr, mo);
    chk("model_13", 64'(mr), 64'd1932053504);
    chk("model_13_ovf", 64'(mo), 64'd1);

    idle(3);
    rst_n = 1'b1;
    idle(2);

    run_job(0, s);
    chk("n0_result", 64'(result), 64'd1);
    chk("n0_latency", 64'(last_done - s), 64'd3);
    run_job(1, s);
    chk("n1_result", 64'(result), 64'd1);
    chk("n1_latency", 64'(last_done - s), 64'd3);

    run_job(5, s);
    chk("n5_result", 64'(result), 64'd120);
    chk("n5_latency", 64'(last_done - s), 64'd43);
    chk("n5_busy_cycles", 64'(busy_cnt), 64'd42);

    for (int k = 0; k <= 20; k++) begin
      run_job(k, s);
      idle(1);
    end

    run_job(12, s);
    chk("n12_result", 64'(result), 64'd479001600);
    chk("n12_ovf", 64'(overflow), 64'd0);
    run_job(13, s);
    chk("n13_result", 64'(result), 64'd1932053504);
    chk("n13_ovf", 64'(overflow), 64'd1);

    run_job(255, s);
    chk("n255_latency", 64'(last_done - s), 64'd2543);
    chk("n255_ovf", 64'(overflow), 64'd1);

    // Start during a running job is ignored.
    drive(1'b1, 6);
    idle(5);
    drive(1'b1, 3);
    idle(lat(6));
    chk("ignore_midjob", 64'(result), 64'd720);

    // Back-to-back: start held in the DONE cycle.
    drive(1'b1, 4);
    idle(lat(4) - 1);
    drive(1'b1, 2);
    idle(lat(2) + 1);
    chk("back_to_back", 64'(result), 64'd2);

    // Reset during MUL of n=7.
    drive(1'b1, 7);
    idle(5);
    #2;
    rst_n    = 1'b0;
    have_job = 1'b0;
    prev_res = '0;
    prev_ovf = 1'b0;
    prev_due = -1;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    run_job(3, s);
    chk("after_rst", 64'(result), 64'd6);

    // Random requests, some landing mid-job or in DONE.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 7) == 0, int'($urandom_range(0, 25)));
    end
    idle(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
